// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs NUM_CH x SAMPLE_W ADC beats LSB-first into sequence-tagged OUT_W words, frame by frame.
// Latency: beat completing a word accepted at edge N -> word at the FIFO head (data_avail) after edge N+1.
// Backpressure: none toward the ADC; a write into a full output FIFO drops that word and sets sticky overflow.
//
// Ports:
//   sys_clk, sys_rst        single clock, synchronous active-high reset
//   start, cont_mode        arm pulse; 1 = re-arm after every frame, 0 = one frame per start
//   in_valid, in_sof,       sample beat, first-beat-of-frame qualifier, NUM_CH samples
//   in_data                 (channel c at [c*SAMPLE_W +: SAMPLE_W])
//   data_rd_en, data_out,   show-ahead FIFO pop / head word / non-empty / occupancy
//   data_avail, fifo_level
//   end_of_frame            1-cycle pulse when the last word of a frame has been written
//   busy                    packer not idle
//   overflow, frame_err     sticky: word dropped on full FIFO / in_sof seen mid-frame
//   frame_cnt               completed frames, wraps at 2^16
module adc_frame_packer #(
    parameter int SAMPLE_W          = 10,
    parameter int NUM_CH            = 1,
    parameter int OUT_W             = 256,
    parameter int SAMPLES_PER_FRAME = 16384,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           start,
    input  logic                           cont_mode,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [NUM_CH*SAMPLE_W-1:0]     in_data,
    input  logic                           data_rd_en,
    output logic [OUT_W-1:0]               data_out,
    output logic                           data_avail,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           end_of_frame,
    output logic                           busy,
    output logic                           overflow,
    output logic                           frame_err,
    output logic [15:0]                    frame_cnt
);
    // Samples per word is a whole number of beats, so a beat never straddles two words.
    localparam int SPW    = (OUT_W / (SAMPLE_W * NUM_CH)) * NUM_CH;
    localparam int DATA_W = SPW * SAMPLE_W;
    localparam int PAD_W  = OUT_W - DATA_W;
    localparam int SEQ_W  = (PAD_W > 0) ? PAD_W : 1;
    localparam int BEAT_W = NUM_CH * SAMPLE_W;
    localparam int WSW    = $clog2(SPW + 1);
    localparam int FSW    = $clog2(SAMPLES_PER_FRAME + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [WSW-1:0] SPW_C = WSW'(SPW);
    localparam logic [WSW-1:0] NCH_W = WSW'(NUM_CH);
    localparam logic [FSW-1:0] SPF_C = FSW'(SAMPLES_PER_FRAME);
    localparam logic [FSW-1:0] NCH_F = FSW'(NUM_CH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]    LVL_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, ARMED, PACK, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] word_acc, acc_nxt;
    logic [WSW-1:0]    wsamp, wsamp_base;
    logic [FSW-1:0]    fsamp, fsamp_nxt;
    logic [SEQ_W-1:0]  seq;
    logic              cont_q;
    logic              take, restart, word_full, fifo_wr;
    logic [OUT_W-1:0]  fifo_din;

    // wsamp reaches SPW when a word is complete; it is written out on the following
    // edge, and a beat arriving on that same edge starts the next word at sample 0.
    assign word_full = (wsamp == SPW_C);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        restart   = 1'b0;
        fifo_wr   = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = ARMED;
            ARMED: if (in_valid && in_sof) begin
                take    = 1'b1;
                restart = 1'b1;
            end
            PACK: begin
                // A completed word still goes out even if this beat resyncs the frame;
                // only the unfinished word is thrown away.
                fifo_wr = word_full;
                if (in_valid) begin
                    take    = 1'b1;
                    restart = in_sof && (fsamp != '0);
                end
            end
            FLUSH: begin
                fifo_wr   = (wsamp != '0);
                state_nxt = cont_q ? ARMED : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        wsamp_base = (restart || word_full) ? '0 : wsamp;
        fsamp_nxt  = restart ? NCH_F : fsamp + NCH_F;
        acc_nxt    = (restart || word_full) ? '0 : word_acc;
        acc_nxt[int'(wsamp_base) * SAMPLE_W +: BEAT_W] = in_data;

        if (take) state_nxt = (fsamp_nxt == SPF_C) ? FLUSH : PACK;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---------------------------------------------------------------- output FIFO
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             rd_ok, wr_ok, fifo_full, fifo_drop;

    assign fifo_full  = (fifo_level == DEPTH_C);
    assign data_avail = (fifo_level != '0);
    assign rd_ok      = data_rd_en && data_avail;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign wr_ok      = fifo_wr && (!fifo_full || rd_ok);
    assign fifo_drop  = fifo_wr && !wr_ok;
    assign data_out   = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wr_ptr] <= fifo_din;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------------------------------------------------------- tag
    generate
        if (PAD_W > 0) begin : g_tag
            assign fifo_din = {seq, word_acc};
        end else begin : g_notag
            assign fifo_din = word_acc;
        end
    endgenerate

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_acc     <= '0;
            wsamp        <= '0;
            fsamp        <= '0;
            seq          <= '0;
            cont_q       <= 1'b0;
            end_of_frame <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            end_of_frame <= (state == FLUSH);

            if (take) begin
                word_acc <= acc_nxt;
                wsamp    <= wsamp_base + NCH_W;
                fsamp    <= fsamp_nxt;
            end else if (fifo_wr || state == FLUSH) begin
                word_acc <= '0;
                wsamp    <= '0;
            end

            // Sequence and frame count advance together with the flush, so every word
            // of a frame (including the flushed partial one) carries the same tag.
            if (state == FLUSH) begin
                fsamp     <= '0;
                seq       <= seq + SEQ_W'(1);
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (state_nxt == FLUSH && state != FLUSH) cont_q <= cont_mode;

            if (state == IDLE && start) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                if (fifo_drop)                  overflow  <= 1'b1;
                if (restart && state == PACK)   frame_err <= 1'b1;
            end
        end
    end
endmodule
